// File: rtl/addr_sel_arbiter_pkg.sv
// Shared types and select encodings for the address-select arbiter.
package addr_sel_pkg;

  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic [SEL_W-1:0] SEL_LOCAL = 2'b00;
  localparam logic [SEL_W-1:0] SEL_MUX2  = 2'b01;
  localparam logic [SEL_W-1:0] SEL_BT    = 2'b10;

endpackage

// File: rtl/addr_sel_arbiter_rr_pick.sv
// Rotating-priority picker: first set req bit at or after rr_ptr, wrapping.
module rr_pick #(
  parameter  int unsigned NUM_CORES = 4,
  localparam int unsigned CW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [CW-1:0]        rr_ptr,
  output logic                 valid,
  output logic [CW-1:0]        index
);

  always_comb begin
    int unsigned j;
    valid = 1'b0;
    index = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      if (!valid && req[CW'(j)]) begin
        valid = 1'b1;
        index = CW'(j);
      end
    end
  end

endmodule

// File: rtl/addr_sel_arbiter.sv
// Round-robin bus arbiter with registered per-core address-mux selects.
// Optional hold limit with forced release enabled by ARB_MAX_HOLD_EN.
module addr_sel_arbiter
  import addr_sel_pkg::*;
#(
  parameter  int unsigned NUM_CORES = 4,
  parameter  int unsigned MAX_HOLD  = 16,
  localparam int unsigned CW        = $clog2(NUM_CORES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CORES-1:0]   bt_req,
  input  logic [NUM_CORES-1:0]   mux2_sel,
  output logic [2*NUM_CORES-1:0] sel_out,
  output logic [NUM_CORES-1:0]   grant,
  output logic [CW-1:0]          grant_id,
  output logic                   busy,
  output logic                   hold_timeout
);

  if (NUM_CORES < 2 || NUM_CORES > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("addr_sel_arbiter: unsupported NUM_CORES/MAX_HOLD");
  end

  arb_state_e             state, state_n;
  logic [CW-1:0]          rr_ptr, rr_ptr_n, rr_next;
  logic [NUM_CORES-1:0]   grant_n, req_eff;
  logic [CW-1:0]          grant_id_n, pick_idx;
  logic                   busy_n, pick_valid;
  logic [2*NUM_CORES-1:0] sel_n;

`ifdef ARB_MAX_HOLD_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
  logic [NUM_CORES-1:0] block, block_n;
  logic                 hold_timeout_n;
`endif

  rr_pick #(.NUM_CORES(NUM_CORES)) u_rr_pick (
    .req    (req_eff),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  assign rr_next = (grant_id == CW'(NUM_CORES - 1)) ? '0 : grant_id + CW'(1);

  // Next-state, next-grant and select computation
  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    grant_n    = grant;
    grant_id_n = grant_id;
    busy_n     = busy;
    sel_n      = '0;
`ifdef ARB_MAX_HOLD_EN
    hold_cnt_n     = hold_cnt;
    hold_timeout_n = 1'b0;
    block_n        = block & bt_req;
    req_eff        = bt_req & ~block;
`else
    req_eff        = bt_req;
`endif

    case (state)
      IDLE: begin
        grant_n    = '0;
        grant_id_n = '0;
        busy_n     = 1'b0;
        if (pick_valid) begin
          state_n    = GRANT;
          grant_n    = NUM_CORES'(1) << pick_idx;
          grant_id_n = pick_idx;
          busy_n     = 1'b1;
`ifdef ARB_MAX_HOLD_EN
          hold_cnt_n = HOLD_W'(1);
`endif
        end
      end
      GRANT: begin
        if (!bt_req[grant_id]) begin
          state_n    = IDLE;
          grant_n    = '0;
          grant_id_n = '0;
          busy_n     = 1'b0;
          rr_ptr_n   = rr_next;
        end
`ifdef ARB_MAX_HOLD_EN
        else if (hold_cnt == HOLD_W'(MAX_HOLD)) begin
          // Forced release; owner stays blocked until it drops its request
          state_n           = IDLE;
          grant_n           = '0;
          grant_id_n        = '0;
          busy_n            = 1'b0;
          rr_ptr_n          = rr_next;
          hold_timeout_n    = 1'b1;
          block_n[grant_id] = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
`endif
      end
      default: ;
    endcase

    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_n[i])       sel_n[2*i +: 2] = SEL_BT;
      else if (mux2_sel[i]) sel_n[2*i +: 2] = SEL_MUX2;
      else                  sel_n[2*i +: 2] = SEL_LOCAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      sel_out  <= '0;
`ifdef ARB_MAX_HOLD_EN
      hold_cnt     <= '0;
      block        <= '0;
      hold_timeout <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      busy     <= busy_n;
      sel_out  <= sel_n;
`ifdef ARB_MAX_HOLD_EN
      hold_cnt     <= hold_cnt_n;
      block        <= block_n;
      hold_timeout <= hold_timeout_n;
`endif
    end
  end

`ifndef ARB_MAX_HOLD_EN
  assign hold_timeout = 1'b0;
`endif

endmodule

// File: doc/addr_sel_arbiter.md
Name: addr_sel_arbiter

Overview:
- Generalised, registered successor to the per-core 2-bit address-select logic of the multicore matrix-multiply datapath.
- Serves NUM_CORES cores that share one memory bus. A round-robin FSM grants the bus to one bus-transfer requester at a time.
- Emits a 2-bit address-mux select per core: bus-transfer, mux2 path, or local.
- Sits between the core array and the shared BRAM address muxes.

Parameters:
NUM_CORES, 4, number of cores/channels (2..16)
MAX_HOLD, 16, max consecutive grant cycles for one owner (used only with ARB_MAX_HOLD_EN)
CW, $clog2(NUM_CORES), width of grant_id (derived localparam, not overridable)

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
bt_req  in  NUM_CORES  per-core bus-transfer request, level, held until done
mux2_sel  in  NUM_CORES  per-core mux2 address-select request
sel_out  out  2*NUM_CORES  per-core select; core i at [2i+1:2i]
grant  out  NUM_CORES  one-hot bus grant (all-zero when idle)
grant_id  out  CW  index of current owner; 0 when idle
busy  out  1  high while state is GRANT
hold_timeout  out  1  1-cycle pulse on forced release; constant 0 without ARB_MAX_HOLD_EN

Behaviour:
- Reset: clk edge with rst_n=0 sets:
  - state=IDLE, rr_ptr=0, hold_cnt=0, block mask=0
  - all outputs 0, including sel_out=0
  - mid-grant reset drops the grant on that edge, with no timeout pulse.
- All outputs are registered. Every output reflects inputs sampled on the previous edge (latency 1).
- Select encoding per core i:
  - 2'b10 when next grant[i]=1
  - 2'b01 when next grant[i]=0 and mux2_sel[i]=1
  - 2'b00 otherwise
  - 2'b11 is never driven
- The bus-transfer grant overrides mux2_sel: when both are present, the output is 2'b10.
- FSM IDLE:
  - Scan bt_req & ~block from index rr_ptr upward, wrapping modulo NUM_CORES.
  - On the first hit k: go to GRANT, grant<=one-hot(k), grant_id<=k, busy<=1, hold_cnt<=1.
  - No request: stay in IDLE.
- FSM GRANT, owner o:
  - Stays while bt_req[o]=1, and hold_cnt increments, saturating.
  - When bt_req[o]=0: go to IDLE, grant<=0, busy<=0, rr_ptr<=(o+1) mod NUM_CORES.
  - A one-cycle IDLE gap between owners is mandatory (bus turnaround), so back-to-back grants are separated by exactly one cycle.
- Requests from non-owners during GRANT are ignored until arbitration in IDLE. No request is lost, because requests are level signals.
- Simultaneous requests: the lowest index at or after rr_ptr wins.
- rr_ptr wrap: owner NUM_CORES-1 → rr_ptr=0.
- mux2_sel is honoured for every non-owner core in every state.

Optional Feature:
- Macro: ARB_MAX_HOLD_EN.
- Defined, in GRANT with hold_cnt==MAX_HOLD and bt_req[o] still 1:
  - forced release: go to IDLE, grant<=0, hold_timeout<=1 for one cycle
  - rr_ptr advances as on a normal release
  - block[o]<=1, so core o is excluded from arbitration until its bt_req falls, which clears block[o]
- Undefined:
  - no hold limit; hold_cnt and block logic are removed
  - hold_timeout is tied to 0

Decomposition:
- Package addr_sel_pkg contains:
  - state encoding (IDLE, GRANT)
  - select constants: SEL_LOCAL=2'b00, SEL_MUX2=2'b01, SEL_BT=2'b10
- Sub-module rr_pick: combinational rotating priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid, index.
  - Parametrised by NUM_CORES.

Test Plan:
(NUM_CORES=4, MAX_HOLD=4)
- Reset → all outputs 0. Reset with bt_req=4'b1111 held → still 0; first grant is core 0 on the edge after rst_n rises.
- Arbitration priority: bt_req=4'b0110, rr_ptr=0 → grant=0010, grant_id=1, sel_out[3:2]=10. Drop bt_req[1] → grant=0 for 1 cycle, then grant=0100.
- Round-robin wrap: core 3 granted then released, with bt_req=4'b1001 → next grant is core 0 (rr_ptr=0).
- mux2 paths: mux2_sel=4'b1111, core 2 granted → sel_out=8'b01_10_01_01. Then bt_req=0 → sel_out=8'b01010101 one cycle later.
- Reset mid-operation: rst_n=0 during GRANT → grant, busy and sel_out are 0 on that edge, and rr_ptr=0.
- ARB_MAX_HOLD_EN, timeout: core 1 holds bt_req for 10 cycles with core 2 also requesting → forced release after 4 grant cycles, hold_timeout pulses once, then core 2 is granted. Core 1 is not re-granted until its bt_req toggles low.
